// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: fetches the instruction at
// CurrentPC over a req/ack port, holds it for the core, then loads NextPC.
//
// Ports:
//   CLK, Reset              clock (rising edge), async active-high reset
//   NextPC, Advance         next PC and retire strobe from the core (HOLD only)
//   IMemReq, IMemAddr       fetch request / address (address == CurrentPC)
//   IMemAck, IMemData       fetch response (FETCH only)
//   CurrentPC               PC of the held or in-flight instruction
//   Instruction, InstrValid fetched instruction and its valid flag
//   MisalignFault           sticky, a misaligned NextPC was loaded
//   FetchError              sticky, fetch timed out
//   InstrCount              retired-instruction count, wraps
module pc_fetch_unit #(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 16,
    parameter int              CNT_W    = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [PC_W-1:0]    NextPC,
    input  logic               Advance,
    output logic               IMemReq,
    output logic [PC_W-1:0]    IMemAddr,
    input  logic               IMemAck,
    input  logic [INSTR_W-1:0] IMemData,
    output logic [PC_W-1:0]    CurrentPC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic               MisalignFault,
    output logic               FetchError,
    output logic [CNT_W-1:0]   InstrCount
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    // Handshake outputs come straight from the state register so there is
    // no combinational path from any input.
    assign IMemReq    = (state == FETCH);
    assign InstrValid = (state == HOLD);
    assign IMemAddr   = CurrentPC;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            CurrentPC     <= RESET_PC;
            Instruction   <= '0;
            InstrCount    <= '0;
            wait_cnt      <= '0;
            MisalignFault <= 1'b0;
            FetchError    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (IMemAck) begin
                        Instruction <= IMemData;
                        wait_cnt    <= '0;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        // Ack has priority: the timeout only fires on a
                        // cycle that ends without one.
                        if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                            FetchError <= 1'b1;
                            state      <= FAULT;
                        end
                    end
                end
                HOLD: begin
                    if (Advance) begin
                        // A misaligned target is still loaded so the bad
                        // PC is visible, but no fetch is issued for it.
                        CurrentPC  <= NextPC;
                        InstrCount <= InstrCount + CNT_W'(1);
                        if (NextPC[1:0] != 2'b00) begin
                            MisalignFault <= 1'b1;
                            state         <= FAULT;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: reset, fetch/retire flow, delayed
// ack, misalignment fault, fetch timeout and reset during a fetch.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic [63:0] NextPC;
    logic        Advance;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        MisalignFault;
    logic        FetchError;
    logic [31:0] InstrCount;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit #(
        .PC_W     (64),
        .INSTR_W  (32),
        .RESET_PC (64'h0),
        .TIMEOUT  (16),
        .CNT_W    (32)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .NextPC        (NextPC),
        .Advance       (Advance),
        .IMemReq       (IMemReq),
        .IMemAddr      (IMemAddr),
        .IMemAck       (IMemAck),
        .IMemData      (IMemData),
        .CurrentPC     (CurrentPC),
        .Instruction   (Instruction),
        .InstrValid    (InstrValid),
        .MisalignFault (MisalignFault),
        .FetchError    (FetchError),
        .InstrCount    (InstrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns later.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(3);
        Reset = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        NextPC   = '0;
        Advance  = 1'b0;
        IMemAck  = 1'b0;
        IMemData = '0;

        // 1) reset state and first fetch
        #2;
        chk("rst_req", IMemReq, 0);
        chk("rst_pc", CurrentPC, 0);
        chk("rst_cnt", InstrCount, 0);
        chk("rst_valid", InstrValid, 0);
        chk("rst_instr", Instruction, 0);
        step(3);
        chk("rst_req_hold", IMemReq, 0);
        Reset = 1'b0;
        chk("idle_req", IMemReq, 0);
        step();
        chk("fetch_req", IMemReq, 1);
        chk("fetch_addr", IMemAddr, 0);
        IMemAck  = 1'b1;
        IMemData = 32'hF84003E9;
        step();
        IMemAck = 1'b0;
        chk("t1_valid", InstrValid, 1);
        chk("t1_instr", Instruction, 32'hF84003E9);
        chk("t1_pc", CurrentPC, 0);
        chk("t1_req", IMemReq, 0);

        // ack outside FETCH is ignored
        IMemAck  = 1'b1;
        IMemData = 32'h12345678;
        step();
        IMemAck = 1'b0;
        chk("hold_ack_instr", Instruction, 32'hF84003E9);
        chk("hold_ack_valid", InstrValid, 1);

        // 2) retire to PC 4
        NextPC  = 64'h4;
        Advance = 1'b1;
        step();
        chk("t2_pc", CurrentPC, 64'h4);
        chk("t2_valid", InstrValid, 0);
        chk("t2_req", IMemReq, 1);
        chk("t2_addr", IMemAddr, 64'h4);
        chk("t2_cnt", InstrCount, 1);

        // 3) delayed ack with Advance held high
        NextPC = 64'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_wait_cnt", InstrCount, 1);
            chk("t3_wait_valid", InstrValid, 0);
            chk("t3_wait_pc", CurrentPC, 64'h4);
        end
        IMemAck  = 1'b1;
        IMemData = 32'h00000013;
        step();
        IMemAck = 1'b0;
        chk("t3_valid", InstrValid, 1);
        chk("t3_instr", Instruction, 32'h00000013);
        chk("t3_cnt_hold", InstrCount, 1);
        step();
        Advance = 1'b0;
        chk("t3_cnt", InstrCount, 2);
        chk("t3_pc", CurrentPC, 64'h8);
        chk("t3_req", IMemReq, 1);

        // Advance outside HOLD is ignored
        Advance = 1'b1;
        NextPC  = 64'h100;
        step();
        Advance = 1'b0;
        chk("fetch_adv_cnt", InstrCount, 2);
        chk("fetch_adv_pc", CurrentPC, 64'h8);

        // 4) misaligned NextPC
        IMemAck  = 1'b1;
        IMemData = 32'h00100093;
        step();
        IMemAck = 1'b0;
        chk("t4_valid", InstrValid, 1);
        NextPC  = 64'hA;
        Advance = 1'b1;
        step();
        chk("t4_pc", CurrentPC, 64'hA);
        chk("t4_mis", MisalignFault, 1);
        chk("t4_req", IMemReq, 0);
        chk("t4_valid0", InstrValid, 0);
        chk("t4_cnt", InstrCount, 3);
        IMemAck = 1'b1;
        NextPC  = 64'h10;
        step(2);
        Advance = 1'b0;
        IMemAck = 1'b0;
        chk("t4_stuck_pc", CurrentPC, 64'hA);
        chk("t4_stuck_cnt", InstrCount, 3);
        chk("t4_stuck_req", IMemReq, 0);
        chk("t4_stuck_instr", Instruction, 32'h00100093);
        chk("t4_ferr", FetchError, 0);

        // 5a) timeout with no ack
        do_reset();
        chk("t5_mis_clr", MisalignFault, 0);
        step();
        chk("t5_req", IMemReq, 1);
        step(15);
        chk("t5_ferr15", FetchError, 0);
        chk("t5_req15", IMemReq, 1);
        step();
        chk("t5_ferr", FetchError, 1);
        chk("t5_req_off", IMemReq, 0);
        chk("t5_valid", InstrValid, 0);

        // 5b) ack on the 16th cycle wins
        do_reset();
        chk("t5b_ferr_clr", FetchError, 0);
        step();
        step(15);
        IMemAck  = 1'b1;
        IMemData = 32'hCAFEF00D;
        step();
        IMemAck = 1'b0;
        chk("t5b_ferr", FetchError, 0);
        chk("t5b_valid", InstrValid, 1);
        chk("t5b_instr", Instruction, 32'hCAFEF00D);

        // 6) five retires, then reset mid-FETCH
        for (int i = 1; i <= 5; i++) begin
            NextPC  = 64'(i * 4);
            Advance = 1'b1;
            step();
            Advance = 1'b0;
            if (i < 5) begin
                IMemAck = 1'b1;
                step();
                IMemAck = 1'b0;
            end
        end
        chk("t6_cnt5", InstrCount, 5);
        chk("t6_pc", CurrentPC, 64'h14);
        chk("t6_req", IMemReq, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("t6_rst_pc", CurrentPC, 0);
        chk("t6_rst_cnt", InstrCount, 0);
        chk("t6_rst_req", IMemReq, 0);
        IMemAck  = 1'b1;
        IMemData = 32'hDEADBEEF;
        step(2);
        chk("t6_rst_valid", InstrValid, 0);
        chk("t6_rst_instr", Instruction, 0);
        Reset = 1'b0;
        step();
        IMemAck = 1'b0;
        chk("t6_late_valid", InstrValid, 0);
        chk("t6_late_req", IMemReq, 1);
        chk("t6_late_instr", Instruction, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
